// File: rtl/nu_pkg.sv
// Shared constants, neuron state encodings and FSM state type for the neuron update unit.
package nu_pkg;

    localparam int N_NEURONS = 20;
    localparam int W_WIDTH   = 10;
    localparam int ACC_WIDTH = 16;

    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } nu_state_t;

endpackage

// File: rtl/nu_mac.sv
// One multiply-accumulate step: acc + weight * neuron, with neuron in {-1, 0, +1}.
module nu_mac
    import nu_pkg::*;
#(
    parameter int WW = 10,
    parameter int AW = 16
) (
    input  logic signed [WW-1:0] weight,
    input  logic        [1:0]    state,
    input  logic signed [AW-1:0] acc,
    output logic signed [AW-1:0] acc_next
);

    logic signed [WW+1:0] wide_s;
    logic signed [WW+1:0] prod_s;

    assign wide_s = {{2{weight[WW-1]}}, weight};

    // Product select; the unused 2'b10 code contributes nothing.
    always_comb begin
        prod_s = '0;
        case (state)
            POS:     prod_s = wide_s;
            NEG:     prod_s = -wide_s;
            default: prod_s = '0;
        endcase
    end

    assign acc_next = acc + {{(AW-WW-2){prod_s[WW+1]}}, prod_s};

endmodule

// File: rtl/neuron_update_unit.sv
// Sequential Hopfield-style neuron update: one weighted sum per start, thresholded and shifted into xalt.
// Optional NEURON_BIAS_EN adds a signed bias port that seeds the accumulator.
module neuron_update_unit #(
    parameter int N_NEURONS = nu_pkg::N_NEURONS,
    parameter int W_WIDTH   = nu_pkg::W_WIDTH
) (
    input  logic                          learn_clock,
    input  logic                          rst_n,
    input  logic [N_NEURONS*W_WIDTH-1:0]  weights_packed,
    input  logic                          load,
    input  logic [2*N_NEURONS-1:0]        init_state,
    input  logic                          start,
`ifdef NEURON_BIAS_EN
    input  logic signed [W_WIDTH-1:0]     bias,
`endif
    output logic signed [1:0]             xin,
    output logic [2*N_NEURONS-1:0]        xalt,
    output logic                          xin_valid,
    output logic                          busy
);

    import nu_pkg::*;

    localparam int ACC_W = W_WIDTH + (ACC_WIDTH - nu_pkg::W_WIDTH);
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    nu_state_t                  state_r;
    nu_state_t                  state_next_s;
    logic [IDX_W-1:0]           idx_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    acc_next_s;
    logic signed [ACC_W-1:0]    acc_init_s;
    logic signed [1:0]          xin_r;
    logic signed [1:0]          xin_new_s;
    logic [2*N_NEURONS-1:0]     xalt_r;
    logic                       xin_valid_r;
    logic                       busy_r;
    logic signed [W_WIDTH-1:0]  weight_s;
    logic [1:0]                 neuron_s;

`ifdef NEURON_BIAS_EN
    assign acc_init_s = {{(ACC_W-W_WIDTH){bias[W_WIDTH-1]}}, bias};
`else
    assign acc_init_s = '0;
`endif

    // Weights are read live; they only change on xin_valid by contract.
    assign weight_s = weights_packed[int'(idx_r)*W_WIDTH +: W_WIDTH];
    assign neuron_s = xalt_r[int'(idx_r)*2 +: 2];

    nu_mac #(
        .WW (W_WIDTH),
        .AW (ACC_W)
    ) u_mac (
        .weight   (weight_s),
        .state    (neuron_s),
        .acc      (acc_r),
        .acc_next (acc_next_s)
    );

    // Next-state logic; load has priority over start in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !load) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = EMIT;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            EMIT:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Sign threshold; a zero sum keeps the previous output.
    always_comb begin
        xin_new_s = xin_r;
        if (acc_r[ACC_W-1]) begin
            xin_new_s = NEG;
        end else if (acc_r != '0) begin
            xin_new_s = POS;
        end else begin
            xin_new_s = xin_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge learn_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            acc_r       <= '0;
            xin_r       <= ZERO;
            xalt_r      <= '0;
            xin_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != IDLE);
            xin_valid_r <= (state_r == EMIT);
            case (state_r)
                IDLE: begin
                    if (load) begin
                        xalt_r <= init_state;
                        xin_r  <= ZERO;
                    end else if (start) begin
                        idx_r <= '0;
                        acc_r <= acc_init_s;
                    end
                end
                ACCUM: begin
                    acc_r <= acc_next_s;
                    idx_r <= idx_r + IDX_W'(1);
                end
                EMIT: begin
                    xin_r  <= xin_new_s;
                    xalt_r <= {xalt_r[2*N_NEURONS-3:0], xin_new_s};
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign xin       = xin_r;
    assign xalt      = xalt_r;
    assign xin_valid = xin_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_neuron_update_unit.sv
// Scoreboard bench for neuron_update_unit: arithmetic reference model, directed and random updates.
module tb_neuron_update_unit;

    localparam int N   = 20;
    localparam int W   = 10;
    localparam int LAT = 21;

    logic               learn_clock = 1'b0;
    logic               rst_n = 1'b0;
    logic               load = 1'b0;
    logic               start = 1'b0;
    logic [N*W-1:0]     weights_packed = '0;
    logic [2*N-1:0]     init_state = '0;
`ifdef NEURON_BIAS_EN
    logic signed [W-1:0] bias = '0;
`endif
    logic signed [1:0]  xin;
    logic [1:0]         xin_u;
    logic [2*N-1:0]     xalt;
    logic               xin_valid;
    logic               busy;

    assign xin_u = xin;

    neuron_update_unit #(.N_NEURONS(N), .W_WIDTH(W)) dut (
        .learn_clock    (learn_clock),
        .rst_n          (rst_n),
        .weights_packed (weights_packed),
        .load           (load),
        .init_state     (init_state),
        .start          (start),
`ifdef NEURON_BIAS_EN
        .bias           (bias),
`endif
        .xin            (xin),
        .xalt           (xalt),
        .xin_valid      (xin_valid),
        .busy           (busy)
    );

    always #5 learn_clock = ~learn_clock;

    int cyc = 0;
    always @(posedge learn_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]     xin;
        logic [2*N-1:0] xalt;
        int             due;
    } exp_t;
    exp_t sb[$];

    int         mw[N];
    logic [1:0] mx[N];
    logic [1:0] mxin;
    int         mbias = 0;
    int         done_cnt = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2*N-1:0] pack_model();
        logic [2*N-1:0] p;
        for (int j = 0; j < N; j++) p[j*2 +: 2] = mx[j];
        return p;
    endfunction

    // Reference: signed sum of weight * neuron value, then sign threshold and shift.
    function automatic int model_update();
        int s;
        int v;
        logic [1:0] nx;
        s = mbias;
        for (int j = 0; j < N; j++) begin
            v = (mx[j] == 2'b01) ? 1 : ((mx[j] == 2'b11) ? -1 : 0);
            s += mw[j] * v;
        end
        nx = (s > 0) ? 2'b01 : ((s < 0) ? 2'b11 : mxin);
        for (int j = N - 1; j > 0; j--) mx[j] = mx[j-1];
        mx[0] = nx;
        mxin  = nx;
        return s;
    endfunction

    // Monitor: pops the scoreboard on every xin_valid and checks pulse width.
    initial begin
        exp_t e;
        forever begin
            @(negedge learn_clock);
            if (prev_valid) check("valid_pulse", {63'd0, xin_valid}, 64'd0);
            if (xin_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("xin", {62'd0, xin_u}, {62'd0, e.xin});
                    check("xalt", {24'd0, xalt}, {24'd0, e.xalt});
                    check("latency", 64'(cyc), 64'(e.due));
                end
                done_cnt++;
            end
            prev_valid = xin_valid;
        end
    end

    task automatic do_load(input logic [2*N-1:0] init);
        @(negedge learn_clock); #1;
        init_state = init;
        load = 1'b1;
        @(posedge learn_clock); #1;
        load = 1'b0;
        for (int j = 0; j < N; j++) mx[j] = init[j*2 +: 2];
        mxin = 2'b00;
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < LAT + 10 && done_cnt == d0; i++) begin
            @(negedge learn_clock); #1;
        end
        check("completion", 64'(done_cnt), 64'(d0 + 1));
        check("busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_update(input bit noise, output int sum);
        exp_t e;
        @(negedge learn_clock); #1;
        for (int j = 0; j < N; j++) weights_packed[j*W +: W] = W'(mw[j]);
`ifdef NEURON_BIAS_EN
        mbias = int'(bias);
`endif
        start = 1'b1;
        @(posedge learn_clock); #1;
        start = 1'b0;
        sum = model_update();
        e.xin  = mxin;
        e.xalt = pack_model();
        e.due  = cyc + LAT;
        sb.push_back(e);
        check("busy_start", {63'd0, busy}, 64'd1);
        if (noise) begin
            repeat (5) @(negedge learn_clock);
            #1;
            init_state = {N{2'b11}};
            load  = 1'b1;
            start = 1'b1;
            @(posedge learn_clock); #1;
            load  = 1'b0;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        int s;
        logic [2*N-1:0] all_pos;
        logic [2*N-1:0] r_init;
        for (int j = 0; j < N; j++) all_pos[j*2 +: 2] = 2'b01;
        for (int j = 0; j < N; j++) mx[j] = 2'b00;
        mxin = 2'b00;

        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, xin_valid}, 64'd0);
        check("rst_xin", {62'd0, xin_u}, 64'd0);
        check("rst_xalt", {24'd0, xalt}, 64'd0);
        @(negedge learn_clock); #1;
        rst_n = 1'b1;

        // All +1 neurons, weights +7.
        do_load(all_pos);
        for (int j = 0; j < N; j++) mw[j] = 7;
        do_update(1'b0, s);
        check("sum_pos", 64'(s), 64'd140);
        check("xin_pos", {62'd0, xin_u}, 64'd1);
        check("xalt_n0n1", {60'd0, xalt[3:0]}, 64'h5);

        // Weights -7.
        do_load(all_pos);
        for (int j = 0; j < N; j++) mw[j] = -7;
        do_update(1'b0, s);
        check("xin_neg", {62'd0, xin_u}, 64'd3);

        // Zero sum with prior xin=11: hold, but still shift.
        for (int j = 0; j < N; j++) mw[j] = (j % 2 == 1) ? 5 : -5;
        mw[0] = 5;
        do_update(1'b0, s);
        check("sum_zero", 64'(s), 64'd0);
        check("xin_hold", {62'd0, xin_u}, 64'd3);

        // Max weights, all -1, with ignored start/load during busy.
        do_load({N{2'b11}});
        for (int j = 0; j < N; j++) mw[j] = 511;
        do_update(1'b1, s);
        check("sum_min", 64'(s), 64'(-10220));
        check("xin_min", {62'd0, xin_u}, 64'd3);

        // Reset in the middle of accumulation.
        do_load(all_pos);
        @(negedge learn_clock); #1;
        start = 1'b1;
        @(posedge learn_clock); #1;
        start = 1'b0;
        repeat (10) @(posedge learn_clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_xalt", {24'd0, xalt}, 64'd0);
        check("abort_xin", {62'd0, xin_u}, 64'd0);
        @(negedge learn_clock); #1;
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) mx[j] = 2'b00;
        mxin = 2'b00;
        do_update(1'b0, s);

        // Load and start together: load wins.
        r_init = {$urandom, $urandom};
        @(negedge learn_clock); #1;
        init_state = r_init;
        load  = 1'b1;
        start = 1'b1;
        @(posedge learn_clock); #1;
        load  = 1'b0;
        start = 1'b0;
        for (int j = 0; j < N; j++) mx[j] = r_init[j*2 +: 2];
        mxin = 2'b00;
        check("ls_busy", {63'd0, busy}, 64'd0);
        @(negedge learn_clock);
        check("ls_busy2", {63'd0, busy}, 64'd0);
        check("ls_xalt", {24'd0, xalt}, {24'd0, r_init});

        // Random updates.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 3) == 0) do_load({$urandom, $urandom});
            for (int j = 0; j < N; j++) mw[j] = int'($urandom_range(0, 1023)) - 512;
`ifdef NEURON_BIAS_EN
            bias = W'($urandom_range(0, 1023));
`endif
            do_update(1'b0, s);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
